// File: rtl/seq_control.sv
// seq_control: multi-cycle instruction sequencer producing the per-phase datapath strobes,
// with fetch wait states, a port handshake with timeout, jump resolution and halt/fault states.
module seq_control #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        do_reset_n,
    input  logic [3:0]  opcode,
    input  logic        isaluop,
    input  logic        fetch_ready,
    input  logic        br_cond,
    input  logic        port_ack,
    output logic        do_fetch,
    output logic        do_regload,
    output logic        do_aluop,
    output logic        do_regstore,
    output logic        do_next,
    output logic        mux_adj,
    output logic        portget,
    output logic        portset,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);
    localparam logic [3:0] OP_LOADLO = 4'h1;
    localparam logic [3:0] OP_JMP    = 4'h2;
    localparam logic [3:0] OP_BR     = 4'h3;
    localparam logic [3:0] OP_IN     = 4'h4;
    localparam logic [3:0] OP_OUT    = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] TMO_LAST  = 4'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_STORE = 3'd4,
        ST_NEXT  = 3'd5,
        ST_HALT  = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP, CL_ALU, CL_LOADLO, CL_JMP, CL_BR, CL_IN, CL_OUT, CL_HALT
    } class_t;

    state_t      state_q, state_d;
    class_t      cls_q, cls_d;
    logic        take_jump_q, take_jump_d;
    logic [3:0]  tmo_q, tmo_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        do_fetch_q, do_fetch_d;
    logic        do_regload_q, do_regload_d;
    logic        do_aluop_q, do_aluop_d;
    logic        do_regstore_q, do_regstore_d;
    logic        do_next_q, do_next_d;
    logic        mux_adj_q, mux_adj_d;
    logic        portget_q, portget_d;
    logic        portset_q, portset_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    function automatic class_t decode_class(input logic alu, input logic [3:0] op);
        if (alu) return CL_ALU;
        case (op)
            OP_LOADLO: return CL_LOADLO;
            OP_JMP:    return CL_JMP;
            OP_BR:     return CL_BR;
            OP_IN:     return CL_IN;
            OP_OUT:    return CL_OUT;
            OP_HALT:   return CL_HALT;
            default:   return CL_NOP;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        take_jump_d   = take_jump_q;
        tmo_d         = tmo_q;
        instr_count_d = instr_count_q;
        case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: if (fetch_ready) state_d = ST_LOAD;
            ST_LOAD: begin
                cls_d   = decode_class(isaluop, opcode);
                tmo_d   = '0;
                state_d = (cls_d == CL_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (!port_ack) tmo_d = tmo_q + 4'd1;
                case (cls_q)
                    CL_ALU, CL_LOADLO: state_d = ST_STORE;
                    CL_JMP: begin
                        take_jump_d = 1'b1;
                        state_d     = ST_NEXT;
                    end
                    CL_BR: begin
                        take_jump_d = br_cond;
                        state_d     = ST_NEXT;
                    end
                    // An ack in the last allowed cycle still wins over the timeout.
                    CL_IN, CL_OUT: begin
                        if (port_ack)
                            state_d = (cls_q == CL_IN) ? ST_STORE : ST_NEXT;
                        else if (tmo_q == TMO_LAST)
                            state_d = ST_FAULT;
                    end
                    default: state_d = ST_NEXT;
                endcase
            end
            ST_STORE: state_d = ST_NEXT;
            ST_NEXT: begin
                instr_count_d = instr_count_q + 16'd1;
                take_jump_d   = 1'b0;
                state_d       = ST_FETCH;
            end
            default: state_d = state_q;
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        do_fetch_d    = (state_d == ST_FETCH);
        do_regload_d  = (state_d == ST_LOAD);
        do_aluop_d    = (state_d == ST_EXEC) && (cls_d == CL_ALU);
        do_regstore_d = (state_d == ST_STORE);
        do_next_d     = (state_d == ST_NEXT);
        mux_adj_d     = (state_d == ST_NEXT) && take_jump_d;
        portget_d     = (state_d == ST_EXEC) && (cls_d == CL_IN);
        portset_d     = (state_d == ST_EXEC) && (cls_d == CL_OUT);
        halted_d      = (state_d == ST_HALT) || (state_d == ST_FAULT);
        fault_d       = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!do_reset_n) begin
            state_q       <= ST_RST;
            cls_q         <= CL_NOP;
            take_jump_q   <= 1'b0;
            tmo_q         <= '0;
            instr_count_q <= '0;
            do_fetch_q    <= 1'b0;
            do_regload_q  <= 1'b0;
            do_aluop_q    <= 1'b0;
            do_regstore_q <= 1'b0;
            do_next_q     <= 1'b0;
            mux_adj_q     <= 1'b0;
            portget_q     <= 1'b0;
            portset_q     <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            take_jump_q   <= take_jump_d;
            tmo_q         <= tmo_d;
            instr_count_q <= instr_count_d;
            do_fetch_q    <= do_fetch_d;
            do_regload_q  <= do_regload_d;
            do_aluop_q    <= do_aluop_d;
            do_regstore_q <= do_regstore_d;
            do_next_q     <= do_next_d;
            mux_adj_q     <= mux_adj_d;
            portget_q     <= portget_d;
            portset_q     <= portset_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign do_fetch    = do_fetch_q;
    assign do_regload  = do_regload_q;
    assign do_aluop    = do_aluop_q;
    assign do_regstore = do_regstore_q;
    assign do_next     = do_next_q;
    assign mux_adj     = mux_adj_q;
    assign portget     = portget_q;
    assign portset     = portset_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign instr_count = instr_count_q;
endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: randomized instruction stream; an instruction-level model predicts each
// retirement/halt record into a scoreboard that a cycle monitor drains and compares.
`timescale 1ns/1ps
module tb_seq_control;
    localparam int TIMEOUT = 15;
    localparam int C_ALU = 0, C_LOADLO = 1, C_JMP = 2, C_BR = 3, C_IN = 4, C_OUT = 5, C_NOP = 6, C_HALT = 7;
    localparam int K_RETIRE = 0, K_HALT = 1, K_FAULT = 2;

    typedef struct {
        int          kind;
        int          lat;
        int          fetch;
        int          alu;
        int          store;
        int          port;
        bit          mux;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        do_reset_n = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        isaluop = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        br_cond = 1'b0;
    logic        port_ack = 1'b0;
    logic        do_fetch, do_regload, do_aluop, do_regstore, do_next;
    logic        mux_adj, portget, portset, halted, fault;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [15:0] model_count = 16'd0;
    logic [3:0]  nop_ops[10] = '{4'h0, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

    seq_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .do_reset_n(do_reset_n), .opcode(opcode), .isaluop(isaluop),
        .fetch_ready(fetch_ready), .br_cond(br_cond), .port_ack(port_ack),
        .do_fetch(do_fetch), .do_regload(do_regload), .do_aluop(do_aluop),
        .do_regstore(do_regstore), .do_next(do_next), .mux_adj(mux_adj),
        .portget(portget), .portset(portset), .halted(halted), .fault(fault),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input longint actual, input longint expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endfunction

    // Predicts the whole-instruction outcome, then drives the handshakes cycle by cycle.
    task automatic applyStimulus(input int cls, input int fw, input int aw, input bit brc, input bit preload);
        exp_t e;
        int   k;
        int   guard;
        bit   is_port;
        is_port = (cls == C_IN) || (cls == C_OUT);
        e = '{default: 0};
        if (preload) model_count = 16'hFFFF;
        e.fetch = fw + 1;
        e.cnt   = model_count;
        if (cls == C_HALT) begin
            e.kind = K_HALT;
            e.lat  = e.fetch + 1;
        end else if (is_port && aw >= TIMEOUT) begin
            e.kind = K_FAULT;
            e.port = TIMEOUT;
            e.lat  = e.fetch + 1 + TIMEOUT;
        end else begin
            e.kind  = K_RETIRE;
            e.alu   = (cls == C_ALU) ? 1 : 0;
            e.store = (cls == C_ALU || cls == C_LOADLO || cls == C_IN) ? 1 : 0;
            e.port  = is_port ? aw + 1 : 0;
            e.lat   = e.fetch + 1 + (is_port ? aw + 1 : 1) + e.store + 1;
            e.mux   = (cls == C_JMP) || (cls == C_BR && brc);
            model_count = model_count + 16'd1;
        end
        sb.push_back(e);

        guard = 0;
        while (!do_fetch && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("fetch_start_bound", 0, 1);
            return;
        end
        k = 0;
        while (do_fetch && guard < 400) begin
            fetch_ready = (k >= fw);
            opcode      = 4'($urandom);
            isaluop     = 1'($urandom);
            br_cond     = 1'($urandom);
            port_ack    = 1'($urandom);
            if (preload && k == 0) force dut.instr_count_q = 16'hFFFF;
            if (preload && k == 1) release dut.instr_count_q;
            k++;
            @(negedge clk);
            guard++;
        end
        isaluop = (cls == C_ALU);
        case (cls)
            C_ALU:    opcode = 4'($urandom);
            C_LOADLO: opcode = 4'h1;
            C_JMP:    opcode = 4'h2;
            C_BR:     opcode = 4'h3;
            C_IN:     opcode = 4'h4;
            C_OUT:    opcode = 4'h5;
            C_HALT:   opcode = 4'hF;
            default:  opcode = nop_ops[$urandom_range(0, 9)];
        endcase
        @(negedge clk);
        opcode  = 4'($urandom);
        isaluop = 1'($urandom);
        k = 0;
        while (state == 3'd3 && guard < 400) begin
            br_cond  = (cls == C_BR) ? brc : 1'($urandom);
            port_ack = is_port ? (k == aw) : 1'($urandom);
            k++;
            @(negedge clk);
            guard++;
        end
        port_ack = 1'($urandom);
        if (guard >= 400) checkOutput("instr_bound", 0, 1);
    endtask

    task automatic doReset(input int cycles);
        do_reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_count", instr_count, 0);
        checkOutput("rst_outputs", {do_fetch, do_regload, do_aluop, do_regstore, do_next,
                                    mux_adj, portget, portset, halted, fault}, 0);
        checkOutput("sb_drained", sb.size(), 0);
        sb.delete();
        model_count = 16'd0;
        do_reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first_fetch", {state, do_fetch}, {3'd1, 1'b1});
    endtask

    int m_lat = 0, m_fetch = 0, m_alu = 0, m_store = 0, m_port = 0;
    bit m_halt_seen = 1'b0;
    exp_t m_e;

    always @(negedge clk) begin
        checkOutput("strobe_legal",
            ((int'(do_fetch) + int'(do_regload) + int'(do_aluop) + int'(do_regstore) + int'(do_next)) <= 1) &&
            (!mux_adj || do_next) && (!(portget || portset) || state == 3'd3) &&
            (!fault || halted) && (halted == (state >= 3'd6)), 1);
        if (state == 3'd0) begin
            m_lat = 0; m_fetch = 0; m_alu = 0; m_store = 0; m_port = 0;
            m_halt_seen = 1'b0;
        end else if (!halted) begin
            m_lat++;
            m_fetch += int'(do_fetch);
            m_alu   += int'(do_aluop);
            m_store += int'(do_regstore);
            m_port  += int'(portget || portset);
            if (do_next) begin
                if (sb.size() == 0) checkOutput("sb_underflow_next", 0, 1);
                else begin
                    m_e = sb.pop_front();
                    checkOutput("kind", K_RETIRE, m_e.kind);
                    checkOutput("latency", m_lat, m_e.lat);
                    checkOutput("fetch_cycles", m_fetch, m_e.fetch);
                    checkOutput("aluop_cycles", m_alu, m_e.alu);
                    checkOutput("regstore_cycles", m_store, m_e.store);
                    checkOutput("port_cycles", m_port, m_e.port);
                    checkOutput("mux_adj", mux_adj, m_e.mux);
                    checkOutput("count_at_next", instr_count, m_e.cnt);
                end
                m_lat = 0; m_fetch = 0; m_alu = 0; m_store = 0; m_port = 0;
            end
        end else if (!m_halt_seen) begin
            m_halt_seen = 1'b1;
            if (sb.size() == 0) checkOutput("sb_underflow_halt", 0, 1);
            else begin
                m_e = sb.pop_front();
                checkOutput("halt_kind", fault ? K_FAULT : K_HALT, m_e.kind);
                checkOutput("halt_latency", m_lat, m_e.lat);
                checkOutput("halt_fetch_cycles", m_fetch, m_e.fetch);
                checkOutput("halt_port_cycles", m_port, m_e.port);
                checkOutput("halt_count", instr_count, m_e.cnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        doReset(3);
        applyStimulus(C_ALU, 0, 0, 1'b0, 1'b0);
        applyStimulus(C_JMP, 3, 0, 1'b0, 1'b0);
        applyStimulus(C_BR, 0, 0, 1'b0, 1'b0);
        applyStimulus(C_BR, 0, 0, 1'b1, 1'b0);
        applyStimulus(C_IN, 0, TIMEOUT - 1, 1'b0, 1'b0);
        applyStimulus(C_OUT, 1, 0, 1'b0, 1'b0);
        applyStimulus(C_LOADLO, 0, 0, 1'b0, 1'b0);
        applyStimulus(C_NOP, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            applyStimulus($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom), 1'b0);

        // Reset landing in the middle of a fetch wait.
        guard = 0;
        while (!do_fetch && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        fetch_ready = 1'b0;
        @(negedge clk);
        checkOutput("fetch_wait_hold", state, 1);
        doReset(1);

        applyStimulus(C_IN, 0, 100, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fault_state", {state, fault, halted}, {3'd7, 1'b1, 1'b1});
        doReset(1);

        applyStimulus(C_ALU, 1, 0, 1'b0, 1'b0);
        applyStimulus(C_OUT, 0, 2, 1'b0, 1'b0);
        applyStimulus(C_HALT, 1, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("halt_state", {state, halted, fault}, {3'd6, 1'b1, 1'b0});
        checkOutput("halt_strobes", {do_fetch, do_regload, do_aluop, do_regstore, do_next,
                                     mux_adj, portget, portset}, 0);
        checkOutput("halt_count_hold", instr_count, 2);
        doReset(1);

        applyStimulus(C_NOP, 2, 0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("wrap_count", instr_count, 0);
        checkOutput("wrap_refetch", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_control.md
# seq_control

Multi-cycle instruction sequencer for the CPU. It drives the per-phase strobes (`do_fetch`, `do_regload`, `do_aluop`, `do_regstore`, `do_next`) consumed by `instr_fetch`, `reg_stack`, `alu` and `instr_pointer`. It adds a fetch wait-state handshake, a port I/O handshake with timeout, branch/jump resolution (`mux_adj`), halt/fault states and a retired-instruction counter. It sits between `instr_decode` (opcode source) and the datapath blocks.

## Interface
- `OP_LOADLO`, 4'h1: load-immediate opcode.
- `OP_JMP`, 4'h2: unconditional relative jump.
- `OP_BR`, 4'h3: conditional relative branch.
- `OP_IN`, 4'h4: port read into register.
- `OP_OUT`, 4'h5: port write.
- `OP_HALT`, 4'hF: stop sequencing.
- `TIMEOUT`, 15: maximum port wait cycles, 1..15.

Ports:
- `clk` input 1: clock; all state changes on its rising edge.
- `do_reset_n` input 1: reset; synchronous, active-low.
- `opcode` input 4: from `instr_decode`; valid from the LOAD state onward.
- `isaluop` input 1: ALU-class instruction flag; overrides `opcode`.
- `fetch_ready` input 1: instruction word valid while `do_fetch` is high.
- `br_cond` input 1: branch condition (register value nonzero), sampled in EXEC.
- `port_ack` input 1: port transfer complete.
- `do_fetch`, `do_regload`, `do_aluop`, `do_regstore`, `do_next` output 1 each: phase strobes.
- `mux_adj` output 1: select jump offset for the pointer adjust; high only in NEXT.
- `portget`, `portset` output 1 each: port read/write request.
- `halted` output 1: in HALT or FAULT.
- `fault` output 1: in FAULT.
- `state` output 3: RST=0, FETCH=1, LOAD=2, EXEC=3, STORE=4, NEXT=5, HALT=6, FAULT=7.
- `instr_count` output 16: count of retired instructions.

## Operation
- All strobes, `mux_adj`, `portget`, `portset`, `halted` and `fault` are Moore outputs decoded from the registered state. They are glitch-free.
- `do_reset_n` low at an edge forces state=RST and `instr_count`=0, and clears the latched opcode class, `take_jump` and the timeout counter. This applies in any state, including mid-wait.
- In RST, every output is 0. RST goes to FETCH unconditionally once reset is high.
- FETCH:
  - `do_fetch`=1.
  - Stays in FETCH while `fetch_ready`=0; there is no timeout.
  - Goes to LOAD at the edge where `fetch_ready`=1.
- LOAD:
  - `do_regload`=1.
  - At the exit edge, latches the class: ALU if `isaluop`=1; otherwise decoded from `opcode`. Unknown non-ALU opcodes are NOP.
  - If the class is HALT, goes to HALT. Otherwise goes to EXEC.
- EXEC, by class:
  - ALU: `do_aluop`=1 for one cycle.
  - LOADLO, NOP: no strobe for one cycle.
  - JMP: sets `take_jump`=1.
  - BR: sets `take_jump`=`br_cond`.
  - IN: holds `portget`=1 until `port_ack`.
  - OUT: holds `portset`=1 until `port_ack`.
- Port wait timeout:
  - The counter is cleared on entry to EXEC and increments on each EXEC cycle with `port_ack`=0.
  - With `port_ack`=1, EXEC exits normally.
  - If the TIMEOUT-th request cycle ends without ack, the next state is FAULT.
  - An ack in the TIMEOUT-th cycle wins over the timeout.
- EXEC exit: ALU, LOADLO and IN go to STORE. JMP, BR, OUT and NOP go to NEXT.
- STORE: `do_regstore`=1 for one cycle, then NEXT.
- NEXT:
  - `do_next`=1 and `mux_adj`=`take_jump`.
  - At the exit edge, `instr_count` increments (wraps FFFF→0000) and `take_jump` clears.
  - Then FETCH.
- HALT and FAULT: `halted`=1 (and `fault`=1 in FAULT), all strobes 0. The only exit is reset. A halted instruction is not counted.

## Timing
- Every strobe is exactly one cycle wide, except:
  - `do_fetch`: 1 + fetch wait cycles.
  - `portget`/`portset`: 1 + ack wait cycles.
- At most one of `do_fetch`/`do_regload`/`do_aluop`/`do_regstore`/`do_next` is high in any cycle.
- Instruction latency with zero waits, FETCH through NEXT:
  - ALU, LOADLO: 5 cycles.
  - JMP, BR, NOP: 4 cycles.
  - IN with ack in first cycle: 5 cycles.
  - OUT with ack in first cycle: 4 cycles.
- First `do_fetch` occurs in the cycle after the edge that samples `do_reset_n`=1.
- `opcode`, `isaluop` and `br_cond` are sampled only at the stated edges. Changes elsewhere have no effect.
- `port_ack` outside EXEC-with-request and `fetch_ready` outside FETCH are ignored.

## Test plan
- Reset, then ALU op (`isaluop`=1), `fetch_ready` tied 1 → state 1,2,3,4,5,1. `do_aluop` and `do_regstore` each one cycle. `instr_count`=1 after NEXT.
- `fetch_ready` low for 3 cycles, then OP_JMP → `do_fetch` 4 cycles, no `do_regstore`, `mux_adj`=1 only in NEXT, 7 cycles total.
- OP_BR with `br_cond`=0, then OP_BR with `br_cond`=1 → `mux_adj` 0 then 1 in the respective NEXT cycles.
- OP_IN, `port_ack` on the 15th request cycle → STORE follows. Repeat with no ack → `portget` high exactly 15 cycles, then state=7, `fault`=`halted`=1.
- OP_HALT after 2 retired instructions → state=6, all strobes 0, `instr_count` stays 2. Then `do_reset_n` low for one edge → state=0, count=0, FETCH next cycle.
- Preload via 65535 retirements (or force) → next NEXT wraps `instr_count` to 0. Reset asserted during a FETCH wait → RST on the next edge.
